// File: rtl/veg_round_ctrl_pkg.sv
// Shared constants and state encoding for the vegetable round sequencer.
// Sprite sizes and playfield bounds live here so hit detection and the
// locator agree on geometry.
package veg_round_ctrl_pkg;

  localparam int unsigned COORD_W  = 11;
  localparam int unsigned VEG_SIZE = 32;
  localparam int unsigned PIG_SIZE = 32;

  localparam int unsigned MIN_X = 0;
  localparam int unsigned MAX_X = 639;
  localparam int unsigned MIN_Y = 0;
  localparam int unsigned MAX_Y = 479;

  typedef enum logic [2:0] {
    StIdle,
    StSpawn,
    StActive,
    StEaten,
    StGameOver
  } round_state_e;

  // Add with a ceiling; assumes ceiling >= step so the subtraction cannot wrap.
  function automatic logic [COORD_W-1:0] sat_add_coord(
    input logic [COORD_W-1:0] value,
    input logic [COORD_W-1:0] step,
    input logic [COORD_W-1:0] ceiling
  );
    if (value >= ceiling - step) begin
      return ceiling;
    end
    return value + step;
  endfunction

endpackage

// File: rtl/veg_hit_detect.sv
// Combinational axis-aligned bounding-box overlap between box A and box B.
// All arithmetic is done on 12-bit zero-extended operands so x + w never wraps.
module veg_hit_detect
  import veg_round_ctrl_pkg::*;
(
  input  logic [COORD_W-1:0] i_a_x,
  input  logic [COORD_W-1:0] i_a_y,
  input  logic [COORD_W-1:0] i_a_w,
  input  logic [COORD_W-1:0] i_a_h,
  input  logic [COORD_W-1:0] i_b_x,
  input  logic [COORD_W-1:0] i_b_y,
  input  logic [COORD_W-1:0] i_b_w,
  input  logic [COORD_W-1:0] i_b_h,
  output logic               o_hit
);

  logic [COORD_W:0] w_a_x_end;
  logic [COORD_W:0] w_a_y_end;
  logic [COORD_W:0] w_b_x_end;
  logic [COORD_W:0] w_b_y_end;

  assign w_a_x_end = {1'b0, i_a_x} + {1'b0, i_a_w};
  assign w_a_y_end = {1'b0, i_a_y} + {1'b0, i_a_h};
  assign w_b_x_end = {1'b0, i_b_x} + {1'b0, i_b_w};
  assign w_b_y_end = {1'b0, i_b_y} + {1'b0, i_b_h};

  // Strict compares: boxes that merely touch edges do not overlap.
  always_comb begin
    o_hit = ({1'b0, i_a_x} < w_b_x_end) && ({1'b0, i_b_x} < w_a_x_end) &&
            ({1'b0, i_a_y} < w_b_y_end) && ({1'b0, i_b_y} < w_a_y_end);
  end

endmodule

// File: rtl/veg_round_ctrl.sv
// Game-round sequencer for the vegetable spawner: issues locator strobes,
// detects pig/vegetable overlap on frame ticks, and tracks score, pig growth
// and the per-vegetable timeout.
// Optional feature macro: VEG_ROUND_SPEEDUP_EN shortens the round reload value
// on every eat, down to a floor; without it the reload is always ROUND_TICKS.
module veg_round_ctrl
  import veg_round_ctrl_pkg::*;
#(
  parameter int unsigned ROUND_TICKS  = 600,
  parameter int unsigned GROWTH_STEP  = 2,
  parameter int unsigned MAX_GROWTH   = 64
`ifdef VEG_ROUND_SPEEDUP_EN
  ,
  parameter int unsigned SPEEDUP_STEP = 30,
  parameter int unsigned MIN_TICKS    = 120
`endif
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start_btn,
  input  logic               i_frame_tick,
  input  logic [COORD_W-1:0] i_pig_x,
  input  logic [COORD_W-1:0] i_pig_y,
  input  logic [COORD_W-1:0] i_veg_x,
  input  logic [COORD_W-1:0] i_veg_y,
  output logic               o_veg_start,
  output logic               o_veg_new_round,
  output logic [COORD_W-1:0] o_pig_growth,
  output logic [7:0]         o_score,
  output logic [9:0]         o_ticks_left,
  output logic               o_veg_visible,
  output logic               o_game_over
);

  localparam logic [9:0]         LP_ROUND_TICKS = 10'(ROUND_TICKS);
  localparam logic [COORD_W-1:0] LP_GROWTH_STEP = COORD_W'(GROWTH_STEP);
  localparam logic [COORD_W-1:0] LP_MAX_GROWTH  = COORD_W'(MAX_GROWTH);
  localparam logic [COORD_W-1:0] LP_PIG_SIZE    = COORD_W'(PIG_SIZE);
  localparam logic [COORD_W-1:0] LP_VEG_SIZE    = COORD_W'(VEG_SIZE);

  round_state_e       r_state;
  logic               r_veg_start;
  logic               r_veg_new_round;
  logic [COORD_W-1:0] r_pig_growth;
  logic [7:0]         r_score;
  logic [9:0]         r_ticks_left;
  logic               r_veg_visible;
  logic               r_game_over;

  logic [COORD_W-1:0] w_pig_size;
  logic               w_hit;
  logic               w_restart;
  logic [9:0]         w_reload;

  assign w_pig_size = LP_PIG_SIZE + r_pig_growth;
  assign w_restart  = i_start_btn && ((r_state == StIdle) || (r_state == StGameOver));

  veg_hit_detect u_hit (
    .i_a_x (i_pig_x),
    .i_a_y (i_pig_y),
    .i_a_w (w_pig_size),
    .i_a_h (w_pig_size),
    .i_b_x (i_veg_x),
    .i_b_y (i_veg_y),
    .i_b_w (LP_VEG_SIZE),
    .i_b_h (LP_VEG_SIZE),
    .o_hit (w_hit)
  );

`ifdef VEG_ROUND_SPEEDUP_EN
  localparam logic [9:0] LP_SPEEDUP_STEP = 10'(SPEEDUP_STEP);
  localparam logic [9:0] LP_MIN_TICKS    = 10'(MIN_TICKS);

  logic [9:0] r_reload;

  // Reload shrinks by one step per eat, clamped at the floor; restart restores it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_reload <= LP_ROUND_TICKS;
    end else if (w_restart) begin
      r_reload <= LP_ROUND_TICKS;
    end else if (r_state == StEaten) begin
      if (r_reload >= LP_MIN_TICKS + LP_SPEEDUP_STEP) begin
        r_reload <= r_reload - LP_SPEEDUP_STEP;
      end else begin
        r_reload <= LP_MIN_TICKS;
      end
    end
  end

  assign w_reload = r_reload;
`else
  assign w_reload = LP_ROUND_TICKS;
`endif

  // Round FSM; every output is a register updated on the transition into its state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state         <= StIdle;
      r_veg_start     <= 1'b0;
      r_veg_new_round <= 1'b0;
      r_pig_growth    <= '0;
      r_score         <= '0;
      r_ticks_left    <= '0;
      r_veg_visible   <= 1'b0;
      r_game_over     <= 1'b0;
    end else begin
      r_veg_start     <= 1'b0;
      r_veg_new_round <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_start_btn) begin
            r_veg_start  <= 1'b1;
            r_score      <= '0;
            r_pig_growth <= '0;
            r_state      <= StSpawn;
          end
        end
        StSpawn: begin
          r_ticks_left  <= w_reload;
          r_veg_visible <= 1'b1;
          r_state       <= StActive;
        end
        StActive: begin
          if (i_frame_tick) begin
            // A hit on the last tick still counts as an eat.
            if (w_hit) begin
              r_veg_new_round <= 1'b1;
              r_veg_visible   <= 1'b0;
              r_state         <= StEaten;
            end else if (r_ticks_left == 10'd1) begin
              r_ticks_left  <= '0;
              r_veg_visible <= 1'b0;
              r_game_over   <= 1'b1;
              r_state       <= StGameOver;
            end else begin
              r_ticks_left <= r_ticks_left - 10'd1;
            end
          end
        end
        StEaten: begin
          // Growth updates after the locator has sampled it with veg_new_round.
          if (r_score != 8'hFF) begin
            r_score <= r_score + 8'd1;
          end
          r_pig_growth <= sat_add_coord(r_pig_growth, LP_GROWTH_STEP, LP_MAX_GROWTH);
          r_state      <= StSpawn;
        end
        StGameOver: begin
          if (i_start_btn) begin
            r_veg_start  <= 1'b1;
            r_game_over  <= 1'b0;
            r_score      <= '0;
            r_pig_growth <= '0;
            r_state      <= StSpawn;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_veg_start     = r_veg_start;
  assign o_veg_new_round = r_veg_new_round;
  assign o_pig_growth    = r_pig_growth;
  assign o_score         = r_score;
  assign o_ticks_left    = r_ticks_left;
  assign o_veg_visible   = r_veg_visible;
  assign o_game_over     = r_game_over;

endmodule

// File: tb/tb_veg_round_ctrl.sv
// Scoreboard bench for veg_round_ctrl: a round-level reference model predicts
// the outputs after each clock edge and queues them; a monitor compares.
module tb_veg_round_ctrl;
  import veg_round_ctrl_pkg::*;

  localparam int RoundTicks  = 600;
  localparam int GrowthStep  = 2;
  localparam int MaxGrowth   = 64;
  localparam int SpeedupStep = 30;
  localparam int MinTicks    = 120;
  localparam int VegSz       = int'(VEG_SIZE);
  localparam int PigSz       = int'(PIG_SIZE);

  localparam int PIdle = 0, PSpawn = 1, PActive = 2, PEaten = 3, POver = 4;

  logic        clk;
  logic        rst_n;
  logic        start_btn;
  logic        frame_tick;
  logic [10:0] pig_x, pig_y, veg_x, veg_y;
  logic        veg_start, veg_new_round, veg_visible, game_over;
  logic [10:0] pig_growth;
  logic [7:0]  score;
  logic [9:0]  ticks_left;

  veg_round_ctrl dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_start_btn     (start_btn),
    .i_frame_tick    (frame_tick),
    .i_pig_x         (pig_x),
    .i_pig_y         (pig_y),
    .i_veg_x         (veg_x),
    .i_veg_y         (veg_y),
    .o_veg_start     (veg_start),
    .o_veg_new_round (veg_new_round),
    .o_pig_growth    (pig_growth),
    .o_score         (score),
    .o_ticks_left    (ticks_left),
    .o_veg_visible   (veg_visible),
    .o_game_over     (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int start;
    int nr;
    int growth;
    int score;
    int ticks;
    int vis;
    int go;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int n_checks = 0;
  int n_errors = 0;

  // Reference model: round-level behaviour in plain integers.
  int m_phase, m_start, m_nr, m_growth, m_score, m_ticks, m_vis, m_go, m_reload;

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  function automatic void model_reset();
    m_phase = PIdle; m_start = 0; m_nr = 0; m_growth = 0; m_score = 0;
    m_ticks = 0; m_vis = 0; m_go = 0; m_reload = RoundTicks;
  endfunction

  function automatic void new_game();
    m_start = 1; m_go = 0; m_score = 0; m_growth = 0;
    m_reload = RoundTicks; m_phase = PSpawn;
  endfunction

  function automatic void model_step(input bit start, input bit tick,
                                     input int px, input int py, input int vx, input int vy);
    bit hit;
    m_start = 0;
    m_nr    = 0;
    case (m_phase)
      PIdle:  if (start) new_game();
      PSpawn: begin m_ticks = m_reload; m_vis = 1; m_phase = PActive; end
      PActive: if (tick) begin
        hit = (px < vx + VegSz) && (vx < px + PigSz + m_growth) &&
              (py < vy + VegSz) && (vy < py + PigSz + m_growth);
        if (hit) begin
          m_nr = 1; m_vis = 0; m_phase = PEaten;
        end else if (m_ticks == 1) begin
          m_ticks = 0; m_vis = 0; m_go = 1; m_phase = POver;
        end else begin
          m_ticks--;
        end
      end
      PEaten: begin
        m_score  = (m_score + 1 > 255) ? 255 : m_score + 1;
        m_growth = (m_growth + GrowthStep > MaxGrowth) ? MaxGrowth : m_growth + GrowthStep;
`ifdef VEG_ROUND_SPEEDUP_EN
        m_reload = (m_reload - SpeedupStep < MinTicks) ? MinTicks : m_reload - SpeedupStep;
`endif
        m_phase = PSpawn;
      end
      POver: if (start) new_game();
      default: m_phase = PIdle;
    endcase
  endfunction

  // Drive one clock's inputs and queue the outputs predicted after the next edge.
  task automatic cycle(input bit start, input bit tick,
                       input int px, input int py, input int vx, input int vy);
    exp_t x;
    @(negedge clk);
    start_btn  = start;
    frame_tick = tick;
    pig_x = 11'(px); pig_y = 11'(py); veg_x = 11'(vx); veg_y = 11'(vy);
    model_step(start, tick, px, py, vx, vy);
    x.start = m_start; x.nr = m_nr; x.growth = m_growth; x.score = m_score;
    x.ticks = m_ticks; x.vis = m_vis; x.go = m_go;
    q.push_back(x);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_veg_start"}, int'(veg_start), 0);
    chk({tag, "_new_round"}, int'(veg_new_round), 0);
    chk({tag, "_growth"}, int'(pig_growth), 0);
    chk({tag, "_score"}, int'(score), 0);
    chk({tag, "_ticks"}, int'(ticks_left), 0);
    chk({tag, "_visible"}, int'(veg_visible), 0);
    chk({tag, "_game_over"}, int'(game_over), 0);
  endtask

  // Monitor: compare the DUT against the queued prediction after each edge.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("veg_start", int'(veg_start), e.start);
      chk("veg_new_round", int'(veg_new_round), e.nr);
      chk("pig_growth", int'(pig_growth), e.growth);
      chk("score", int'(score), e.score);
      chk("ticks_left", int'(ticks_left), e.ticks);
      chk("veg_visible", int'(veg_visible), e.vis);
      chk("game_over", int'(game_over), e.go);
    end
  end

  initial begin
    int guard;
    rst_n = 1'b0; start_btn = 1'b0; frame_tick = 1'b0;
    pig_x = '0; pig_y = '0; veg_x = '0; veg_y = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Idle: frame ticks alone do nothing.
    repeat (5) cycle(0, 1'($urandom_range(0, 1)), 100, 100, 110, 110);

    // Start, spawn, active with full reload.
    cycle(1, 1, 100, 100, 400, 400);
    repeat (3) cycle(0, 0, 100, 100, 400, 400);

    // Overlap eat.
    cycle(0, 1, 100, 100, 110, 110);
    repeat (4) cycle(0, 0, 100, 100, 110, 110);

    // Randomised play, including restarts after game over.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 150)), int'($urandom_range(0, 150)),
            int'($urandom_range(0, 300)), int'($urandom_range(0, 300)));
    end

    // Timeout: no overlap, tick every cycle until game over, then extra ticks.
    cycle(1, 1, 100, 100, 400, 400);
    guard = 0;
    while (m_phase != POver && guard < 2000) begin
      cycle(0, 1, 100, 100, 400, 400);
      guard++;
    end
    chk("timeout_reached_bound", int'(guard < 2000), 1);
    repeat (20) cycle(0, 1, 100, 100, 400, 400);

    // Restart with a frame tick on the same cycle.
    cycle(1, 1, 100, 100, 400, 400);

    // Hit on the last remaining tick beats timeout.
    guard = 0;
    while (!(m_phase == PActive && m_ticks == 1) && guard < 2000) begin
      cycle(0, 1, 100, 100, 400, 400);
      guard++;
    end
    chk("last_tick_bound", int'(guard < 2000), 1);
    cycle(0, 1, 100, 100, 110, 110);

    // Many consecutive eats: growth and score saturation, reload floor.
    for (int i = 0; i < 900; i++) cycle(0, 1, 100, 100, 110, 110);

    // Async reset while in EATEN.
    guard = 0;
    while (m_phase != PEaten && guard < 10) begin
      cycle(0, 1, 100, 100, 110, 110);
      guard++;
    end
    chk("eaten_bound", int'(guard < 10), 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all_zero("async_rst");
    @(posedge clk);
    #1;
    check_all_zero("rst_held");
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1, 0, 100, 100, 110, 110);
    repeat (4) cycle(0, 1, 100, 100, 110, 110);

    repeat (2) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
